// File: rtl/tx_word_src_if.sv
// Transmit-word source bus: control/pattern inputs and the word output.
interface tx_word_src_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] const_word;
  logic [30:0]      prbs_seed;
  logic             reseed;
  logic             pat_wr_en;
  logic [AW-1:0]    pat_wr_addr;
  logic [WIDTH-1:0] pat_wr_data;
  logic [AW-1:0]    pat_last;
  logic             inj_err;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             err_injected;

  modport master (
    output en, mode, const_word, prbs_seed, reseed,
    output pat_wr_en, pat_wr_addr, pat_wr_data, pat_last,
    output inj_err,
    input  dout, dout_valid, err_injected
  );

  modport slave (
    input  en, mode, const_word, prbs_seed, reseed,
    input  pat_wr_en, pat_wr_addr, pat_wr_data, pat_last,
    input  inj_err,
    output dout, dout_valid, err_injected
  );
endinterface

// File: rtl/tx_word_src.sv
// 16-bit transmit-word source: constant, PRBS31 (16 bits/cycle),
// pattern loop or hold, with single-shot bit-15 error injection.
module tx_word_src #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input logic         clk,
  input logic         rst,
  tx_word_src_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] M_CONST = 2'd0;
  localparam logic [1:0] M_PRBS  = 2'd1;
  localparam logic [1:0] M_PAT   = 2'd2;
  localparam logic [1:0] M_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    SEED,
    IDLE,
    RUN
  } state_t;

  state_t           r_state;
  logic [30:0]      r_lfsr;
  logic [AW-1:0]    r_ptr;
  logic [1:0]       r_pmode;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_err;
  logic             r_inj_q;
  logic             r_pend;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [30:0]      w_seed;
  logic [30:0]      w_lfsr_nxt;
  logic [WIDTH-1:0] w_prbs;
  logic [AW-1:0]    w_rd_ptr;
  logic [AW-1:0]    w_ptr_nxt;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_flip;
  logic             w_emit;
  logic             w_rise;

  // An all-zero seed would lock the LFSR, so it maps to all ones.
  always_comb begin
    w_seed = bus.prbs_seed;
    if (bus.prbs_seed == 31'd0) begin
      w_seed = '1;
    end
  end

  always_comb begin
    logic b;
    w_lfsr_nxt = r_lfsr;
    w_prbs     = '0;
    for (int i = 0; i < 16; i++) begin
      b              = w_lfsr_nxt[30] ^ w_lfsr_nxt[27];
      w_prbs[15-i]   = b;
      w_lfsr_nxt     = {w_lfsr_nxt[29:0], b};
    end
  end

  // Entering the loop from another mode restarts at word 0.
  always_comb begin
    w_rd_ptr = '0;
    if (r_pmode == M_PAT) begin
      w_rd_ptr = r_ptr;
    end
    w_ptr_nxt = w_rd_ptr + 1'b1;
    if (w_rd_ptr >= bus.pat_last) begin
      w_ptr_nxt = '0;
    end
  end

  always_comb begin
    w_word = r_word;
    unique case (bus.mode)
      M_CONST: w_word = bus.const_word;
      M_PRBS:  w_word = w_prbs;
      M_PAT:   w_word = r_mem[w_rd_ptr];
      M_HOLD:  w_word = r_word;
    endcase
  end

  assign w_emit = (r_state != SEED) && bus.en;
  assign w_rise = bus.inj_err && !r_inj_q;
  assign w_flip = {r_pend, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.pat_wr_en) begin
      r_mem[bus.pat_wr_addr] <= bus.pat_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEED;
      r_lfsr  <= '1;
      r_ptr   <= '0;
      r_pmode <= M_CONST;
      r_word  <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_inj_q <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_inj_q <= bus.inj_err;
      r_err   <= 1'b0;
      if (bus.reseed) begin
        r_state <= SEED;
        r_valid <= 1'b0;
        r_pend  <= 1'b0;
      end else begin
        unique case (r_state)
          SEED: begin
            r_lfsr  <= w_seed;
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
          IDLE, RUN: begin
            if (bus.en) begin
              r_state <= RUN;
              r_word  <= w_word;
              r_dout  <= w_word ^ w_flip;
              r_valid <= 1'b1;
              r_err   <= r_pend;
              r_pmode <= bus.mode;
              if (bus.mode == M_PRBS) begin
                r_lfsr <= w_lfsr_nxt;
              end
              if (bus.mode == M_PAT) begin
                r_ptr <= w_ptr_nxt;
              end
            end else begin
              r_state <= IDLE;
              r_valid <= 1'b0;
            end
          end
          default: r_state <= SEED;
        endcase
        // A second edge while pending merges into the same injection.
        if (w_emit && r_pend) begin
          r_pend <= 1'b0;
        end else if (w_rise) begin
          r_pend <= 1'b1;
        end
      end
    end
  end

  assign bus.dout         = r_dout;
  assign bus.dout_valid   = r_valid;
  assign bus.err_injected = r_err;
endmodule

// File: tb/tb_tx_word_src.sv
// Directed bench for tx_word_src: PRBS, pattern loop, stall,
// error injection, reseed and reset.
module tb_tx_word_src;
  logic clk;
  logic rst;

  tx_word_src_if #(.WIDTH(16), .DEPTH(16)) bus ();

  tx_word_src #(.WIDTH(16), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_run;
  int n_fail;
  logic [30:0] m_s;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference PRBS31 word, MSB = first generated bit.
  task automatic mword(output logic [15:0] w);
    logic b;
    for (int i = 0; i < 16; i++) begin
      b = m_s[30] ^ m_s[27];
      w[15-i] = b;
      m_s = {m_s[29:0], b};
    end
  endtask

  task automatic run_prbs(input string tag, input int n);
    logic [15:0] w;
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      mword(w);
      step();
      if (bus.dout !== w || bus.dout_valid !== 1'b1) errs++;
    end
    check(tag, errs, 0);
  endtask

  initial begin
    int cnt;
    logic [15:0] w;
    n_run  = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.mode = 2'd1;
    bus.const_word = 16'h0000;
    bus.prbs_seed = 31'h7FFF_FFFF;
    bus.reseed = 1'b0;
    bus.pat_wr_en = 1'b0;
    bus.pat_wr_addr = '0;
    bus.pat_wr_data = '0;
    bus.pat_last = 4'd3;
    bus.inj_err = 1'b0;
    step();
    step();
    check("rst_dout", bus.dout, 16'h0000);
    check("rst_valid", bus.dout_valid, 1'b0);
    check("rst_err", bus.err_injected, 1'b0);
    rst = 1'b0;
    step();
    check("seed_valid", bus.dout_valid, 1'b0);
    step();
    check("prbs_w1_v", bus.dout_valid, 1'b1);
    check("prbs_w1", bus.dout, 16'h0000);
    step();
    check("prbs_w2", bus.dout, 16'h000E);
    m_s = 31'h7FFF_FFFF;
    mword(w);
    mword(w);
    run_prbs("prbs_run", 500);

    bus.en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.dout_valid === 1'b0) cnt++;
    end
    check("stall_len", cnt, 5);
    bus.en = 1'b1;
    run_prbs("resume", 40);

    bus.prbs_seed = 31'd0;
    bus.reseed = 1'b1;
    step();
    check("rs_v0", bus.dout_valid, 1'b0);
    bus.reseed = 1'b0;
    step();
    check("rs_v1", bus.dout_valid, 1'b0);
    step();
    check("rs_w1_v", bus.dout_valid, 1'b1);
    check("rs_w1", bus.dout, 16'h0000);
    step();
    check("rs_w2", bus.dout, 16'h000E);
    m_s = 31'h7FFF_FFFF;
    mword(w);
    mword(w);
    run_prbs("zero_seed_run", 100);

    bus.mode = 2'd0;
    bus.const_word = 16'h00FF;
    step();
    check("const", bus.dout, 16'h00FF);
    bus.mode = 2'd3;
    bus.const_word = 16'h1234;
    step();
    step();
    check("hold", bus.dout, 16'h00FF);
    check("hold_v", bus.dout_valid, 1'b1);
    bus.mode = 2'd0;
    step();
    check("const2", bus.dout, 16'h1234);
    bus.const_word = 16'h00FF;
    step();

    bus.inj_err = 1'b1;
    step();
    check("inj_pre", bus.dout, 16'h00FF);
    check("inj_pre_e", bus.err_injected, 1'b0);
    step();
    check("inj_word", bus.dout, 16'h80FF);
    check("inj_pulse", bus.err_injected, 1'b1);
    step();
    check("inj_post", bus.dout, 16'h00FF);
    check("inj_post_e", bus.err_injected, 1'b0);
    bus.inj_err = 1'b0;
    step();

    bus.en = 1'b0;
    step();
    bus.inj_err = 1'b1;
    step();
    bus.inj_err = 1'b0;
    step();
    bus.inj_err = 1'b1;
    step();
    bus.inj_err = 1'b0;
    step();
    bus.en = 1'b1;
    step();
    check("inj2_word", bus.dout, 16'h80FF);
    cnt = (bus.err_injected === 1'b1) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.err_injected === 1'b1) cnt++;
    end
    check("inj2_count", cnt, 1);

    bus.pat_wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.pat_wr_addr = 4'(i);
      bus.pat_wr_data = 16'hA001 + 16'(i);
      step();
    end
    bus.pat_wr_en = 1'b0;
    bus.pat_last = 4'd3;
    bus.mode = 2'd2;
    step();
    check("pat0", bus.dout, 16'hA001);
    step();
    check("pat1", bus.dout, 16'hA002);
    step();
    check("pat2", bus.dout, 16'hA003);
    step();
    check("pat3", bus.dout, 16'hA004);
    step();
    check("pat_wrap", bus.dout, 16'hA001);
    bus.mode = 2'd0;
    step();
    check("pat_const", bus.dout, 16'h00FF);
    bus.mode = 2'd2;
    step();
    check("pat_restart", bus.dout, 16'hA001);
    step();
    step();
    check("pat_a003", bus.dout, 16'hA003);
    bus.pat_last = 4'd1;
    step();
    check("shrink_tail", bus.dout, 16'hA004);
    step();
    check("shrink_w0", bus.dout, 16'hA001);
    step();
    check("shrink_w1", bus.dout, 16'hA002);
    bus.pat_wr_en = 1'b1;
    bus.pat_wr_addr = 4'd0;
    bus.pat_wr_data = 16'hB001;
    step();
    check("wr_old", bus.dout, 16'hA001);
    bus.pat_wr_en = 1'b0;
    step();
    check("wr_a002", bus.dout, 16'hA002);
    step();
    check("wr_new", bus.dout, 16'hB001);

    rst = 1'b1;
    step();
    check("mrst_dout", bus.dout, 16'h0000);
    check("mrst_valid", bus.dout_valid, 1'b0);
    rst = 1'b0;
    bus.pat_last = 4'd3;
    step();
    step();
    check("mem_clr_v", bus.dout_valid, 1'b1);
    check("mem_clr0", bus.dout, 16'h0000);
    step();
    check("mem_clr1", bus.dout, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
